// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ==========================================================================
// seven_segment_scanner : multiplexed common-anode 7-seg driver, tear-free load
// Revision 1.0
// ==========================================================================
module seven_segment_scanner #(
  parameter int DIGITS_NUM  = 4,
  parameter int BLANK_TICKS = 1,
  parameter int ON_TICKS    = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clk_en_i,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*DIGITS_NUM-1:0] data_i,
  input  logic [DIGITS_NUM-1:0]   dp_i,
  input  logic [DIGITS_NUM-1:0]   blank_i,
  output logic [DIGITS_NUM-1:0]   anode_o,
  output logic [6:0]              cathode_o,
  output logic                    dp_o,
  output logic                    pending_o,
  output logic                    frame_o
);

  localparam int IDX_W     = $clog2(DIGITS_NUM);
  localparam int MAX_TICKS = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
  localparam int TICK_W    = $clog2(MAX_TICKS + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS_NUM - 1);
  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
  localparam logic [TICK_W-1:0] ON_LAST    = TICK_W'(ON_TICKS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [4*DIGITS_NUM-1:0] shadow_data_q, shadow_data_d, active_data_q, active_data_d;
  logic [DIGITS_NUM-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic [DIGITS_NUM-1:0]   shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
  logic                    pending_q, pending_d;
  logic [DIGITS_NUM-1:0]   anode_q, anode_d;
  logic [6:0]              cathode_q, cathode_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;
  logic                    wrap;
  logic                    commit;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_comb begin
    state_d        = state_q;
    digit_idx_d    = digit_idx_q;
    tick_cnt_d     = tick_cnt_q;
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    active_blank_d = active_blank_q;
    pending_d      = pending_q;
    wrap           = 1'b0;

    if (!enable_i) begin
      state_d     = ST_BLANK;
      digit_idx_d = '0;
      tick_cnt_d  = '0;
    end else if (clk_en_i) begin
      case (state_q)
        ST_BLANK: begin
          if (tick_cnt_q == BLANK_LAST) begin
            state_d    = ST_DRIVE;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (tick_cnt_q == ON_LAST) begin
            state_d    = ST_BLANK;
            tick_cnt_d = '0;
            if (digit_idx_q == LAST_IDX) begin
              digit_idx_d = '0;
              wrap        = 1'b1;
            end else begin
              digit_idx_d = digit_idx_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

    // Commit sees the pre-load shadow; a same-cycle load re-arms pending.
    commit = pending_q && (wrap || !enable_i);
    if (commit) begin
      active_data_d  = shadow_data_q;
      active_dp_d    = shadow_dp_q;
      active_blank_d = shadow_blank_q;
      pending_d      = 1'b0;
    end
    if (load_i) begin
      shadow_data_d  = data_i;
      shadow_dp_d    = dp_i;
      shadow_blank_d = blank_i;
      pending_d      = 1'b1;
    end

    // Outputs follow the next state so they change on the entering edge.
    anode_d   = '1;
    cathode_d = 7'h7F;
    dp_d      = 1'b1;
    frame_d   = wrap;
    if (state_d == ST_DRIVE) begin
      anode_d[digit_idx_d] = 1'b0;
      if (!active_blank_q[digit_idx_d]) begin
        cathode_d = hex_decode(active_data_q[{digit_idx_d, 2'b00} +: 4]);
        dp_d      = ~active_dp_q[digit_idx_d];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_BLANK;
      digit_idx_q    <= '0;
      tick_cnt_q     <= '0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blank_q <= '0;
      pending_q      <= 1'b0;
      anode_q        <= '1;
      cathode_q      <= 7'h7F;
      dp_q           <= 1'b1;
      frame_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      digit_idx_q    <= digit_idx_d;
      tick_cnt_q     <= tick_cnt_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      active_blank_q <= active_blank_d;
      pending_q      <= pending_d;
      anode_q        <= anode_d;
      cathode_q      <= cathode_d;
      dp_q           <= dp_d;
      frame_q        <= frame_d;
    end
  end

  assign anode_o   = anode_q;
  assign cathode_o = cathode_q;
  assign dp_o      = dp_q;
  assign pending_o = pending_q;
  assign frame_o   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ==========================================================================
// tb_seven_segment_scanner : randomized bench against a frame-position model
// Revision 1.0
// ==========================================================================
module tb_seven_segment_scanner;

  localparam int NUM   = 4;
  localparam int BL    = 1;
  localparam int ON    = 3;
  localparam int SLOT  = BL + ON;
  localparam int FRAME = SLOT * NUM;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            clk_en_i, enable_i, load_i;
  logic [4*NUM-1:0] data_i;
  logic [NUM-1:0]  dp_i, blank_i;
  logic [NUM-1:0]  anode_o;
  logic [6:0]      cathode_o;
  logic            dp_o, pending_o, frame_o;

  seven_segment_scanner #(
    .DIGITS_NUM (NUM),
    .BLANK_TICKS(BL),
    .ON_TICKS   (ON)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clk_en_i (clk_en_i),
    .enable_i (enable_i),
    .load_i   (load_i),
    .data_i   (data_i),
    .dp_i     (dp_i),
    .blank_i  (blank_i),
    .anode_o  (anode_o),
    .cathode_o(cathode_o),
    .dp_o     (dp_o),
    .pending_o(pending_o),
    .frame_o  (frame_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] hex_tab [16];

  // Model: position within the frame, counted in scan strobes.
  int          m_pos;
  logic [15:0] m_sd, m_ad;
  logic [3:0]  m_sp, m_sb, m_ap, m_ab;
  logic        m_pend, m_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pos = 0; m_sd = '0; m_ad = '0; m_sp = '0; m_sb = '0;
    m_ap = '0; m_ab = '0; m_pend = 1'b0; m_frame = 1'b0;
  endtask

  task automatic model_edge();
    logic wrap_e, commit_e;
    wrap_e   = enable_i && clk_en_i && (m_pos == FRAME - 1);
    commit_e = m_pend && (wrap_e || !enable_i);
    if (!enable_i)     m_pos = 0;
    else if (clk_en_i) m_pos = (m_pos + 1) % FRAME;
    m_frame = wrap_e;
    if (commit_e) begin
      m_ad = m_sd; m_ap = m_sp; m_ab = m_sb; m_pend = 1'b0;
    end
    if (load_i) begin
      m_sd = data_i; m_sp = dp_i; m_sb = blank_i; m_pend = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    int digit;
    logic [3:0] one_hot, exp_an, nib;
    logic [6:0] exp_cat;
    logic       exp_dp;
    digit   = m_pos / SLOT;
    exp_an  = 4'hF;
    exp_cat = 7'h7F;
    exp_dp  = 1'b1;
    if ((m_pos % SLOT) >= BL) begin
      one_hot = 4'b0001 << digit;
      exp_an  = ~one_hot;
      nib     = m_ad[digit*4 +: 4];
      if (!m_ab[digit]) begin
        exp_cat = hex_tab[nib];
        exp_dp  = ~m_ap[digit];
      end
    end
    check({tag, ".anode"},   32'(anode_o),   32'(exp_an));
    check({tag, ".cathode"}, 32'(cathode_o), 32'(exp_cat));
    check({tag, ".dp"},      32'(dp_o),      32'(exp_dp));
    check({tag, ".pending"}, 32'(pending_o), 32'(m_pend));
    check({tag, ".frame"},   32'(frame_o),   32'(m_frame));
  endtask

  task automatic step(input string tag, input logic en, input logic ce, input logic ld,
                      input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    enable_i = en; clk_en_i = ce; load_i = ld;
    data_i = d; dp_i = p; blank_i = b;
    @(posedge clk_i);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset_i = 1'b1; enable_i = 1'b0; clk_en_i = 1'b0; load_i = 1'b0;
    data_i = '0; dp_i = '0; blank_i = '0;
    model_reset();
    #12;
    check_outputs("reset");
    reset_i = 1'b0;

    // Load 1234 while dark so it commits, then scan continuously.
    step("load_dark", 1'b0, 1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
    step("commit_dark", 1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    for (int i = 0; i < 40; i++) step("scan1234", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // Mid-frame load of ABCD, with blank/dp patterns on the next load.
    for (int i = 0; i < 6; i++) step("pre_abcd", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step("load_abcd", 1'b1, 1'b1, 1'b1, 16'hABCD, 4'b0001, 4'b0100);
    for (int i = 0; i < 36; i++) step("scan_abcd", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // Load 5555, then 6666 exactly on the wrap edge.
    if (m_pos == FRAME - 1) step("align", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step("load_5555", 1'b1, 1'b1, 1'b1, 16'h5555, 4'h0, 4'h0);
    for (int i = 0; i < FRAME && m_pos != FRAME - 1; i++)
      step("to_wrap", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step("load_on_wrap", 1'b1, 1'b1, 1'b1, 16'h6666, 4'h0, 4'h0);
    check("wrap_load.pending", 32'(pending_o), 32'd1);
    for (int i = 0; i < 36; i++) step("scan_6666", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // Disable mid-DRIVE of digit 2, then re-enable.
    for (int i = 0; i < FRAME && m_pos != 2*SLOT + BL + 1; i++)
      step("to_d2", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step("disable", 1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) step("reenable", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // Strobe every 5th cycle.
    for (int i = 0; i < 200; i++)
      step("ce5", 1'b1, (i % 5) == 4, (i % 37) == 3, 16'($urandom), 4'($urandom), 4'($urandom));

    // Fully random traffic.
    for (int i = 0; i < 2000; i++)
      step("rand", ($urandom_range(0, 29) != 0), 1'($urandom), ($urandom_range(0, 19) == 0),
           16'($urandom), 4'($urandom), 4'($urandom));

    // Async reset between edges while driving with pending data.
    for (int i = 0; i < FRAME && (m_pos % SLOT) < BL; i++)
      step("to_drive", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step("pre_reset_load", 1'b1, 1'b0, 1'b1, 16'h9876, 4'h0, 4'h0);
    #2 reset_i = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    #1 reset_i = 1'b0;
    for (int i = 0; i < 20; i++) step("post_reset", 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
